// File: rtl/cache_set_arbiter_pkg.sv
// Shared types and constants for the cache set arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_SET_LATENCY = 1;

  // Latency counter is sized for the largest supported set latency (7).
  localparam int unsigned CNT_W = 3;

  // Width of a requester index; NUM_REQ is at least 2, so this is never 0.
  function automatic int unsigned id_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cache_set_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_picker
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IW      = id_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqValid,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      winner,
  output logic               anyValid
);

  // Scan from ptr with wrap-around, keeping only the first hit.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    grant    = '0;
    winner   = '0;
    anyValid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!anyValid && reqValid[idx]) begin
        anyValid   = 1'b1;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/cache_set_arbiter.sv
// Round-robin sequencer sharing one CacheSet datapath among NUM_REQ clients.
module cache_set_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned SET_LATENCY = DEF_SET_LATENCY
) (
  input  logic                          clock,
  input  logic                          clearN,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  output logic [NUM_REQ-1:0]            respValid,
  output logic [DATA_WIDTH-1:0]         respData,
  input  logic [NUM_REQ-1:0]            respReady,
  output logic [DATA_WIDTH-1:0]         setRequest,
  input  logic [DATA_WIDTH-1:0]         setResponse,
  output logic                          busy,
  output logic [id_width(NUM_REQ)-1:0]  grantId
);

  localparam int unsigned IW = id_width(NUM_REQ);

  arb_state_t           state;
  logic [IW-1:0]        ptr;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_REQ-1:0]   pickGrant;
  logic [IW-1:0]        pickIdx;
  logic                 pickAny;
  logic [IW-1:0]        ptrNext;
  logic [DATA_WIDTH-1:0] selData;
  logic                 ownerAck;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .reqValid (reqValid),
    .ptr      (ptr),
    .grant    (pickGrant),
    .winner   (pickIdx),
    .anyValid (pickAny)
  );

  // Grant strobe only in IDLE and never while reset is asserted.
  always_comb begin
    reqReady = '0;
    if (state == IDLE && clearN) reqReady = pickGrant;
  end

  // Payload of the current winner and the pointer just past it.
  always_comb begin
    selData = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pickGrant[i]) selData = reqData[i*DATA_WIDTH +: DATA_WIDTH];
    end
    ptrNext = (pickIdx == IW'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
  end

  // Response valid decoded from state and owner; non-owner acks are masked.
  always_comb begin
    respValid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      respValid[i] = (state == RESP) && (grantId == IW'(i));
    end
    ownerAck = |(respValid & respReady);
    busy     = (state != IDLE);
  end

  // Transaction FSM: accept, wait out the set latency, hold response until ack.
  always_ff @(posedge clock or negedge clearN) begin
    if (!clearN) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      grantId    <= '0;
      setRequest <= '0;
      respData   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pickAny) begin
            setRequest <= selData;
            grantId    <= pickIdx;
            ptr        <= ptrNext;
            cnt        <= CNT_W'(SET_LATENCY);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            respData <= setResponse;
            state    <= RESP;
          end
        end
        RESP: begin
          if (ownerAck) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_set_arbiter.sv
// Scoreboard bench for cache_set_arbiter with an inverting registered set model.
module tb_cache_set_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clock = 1'b0;
  logic clearN = 1'b0;
  always #5 clock = ~clock;

  // Default-latency instance
  logic [N-1:0]   reqValid, reqReady, respValid, respReady, respReadyMan;
  logic [N*W-1:0] reqData;
  logic [W-1:0]   respData, setRequest, setResponse;
  logic           busy;
  logic [1:0]     grantId;
  bit             autoAck;

  assign respReady = autoAck ? respValid : respReadyMan;

  always @(posedge clock or negedge clearN)
    if (!clearN) setResponse <= '0;
    else         setResponse <= ~setRequest;

  cache_set_arbiter #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (W),
    .SET_LATENCY (1)
  ) u_dut (
    .clock       (clock),
    .clearN      (clearN),
    .reqValid    (reqValid),
    .reqData     (reqData),
    .reqReady    (reqReady),
    .respValid   (respValid),
    .respData    (respData),
    .respReady   (respReady),
    .setRequest  (setRequest),
    .setResponse (setResponse),
    .busy        (busy),
    .grantId     (grantId)
  );

  // Latency-3 instance
  logic [N-1:0]   reqValid3, reqReady3, respValid3, respReady3;
  logic [N*W-1:0] reqData3;
  logic [W-1:0]   respData3, setRequest3, setResponse3;
  logic           busy3;
  logic [1:0]     grantId3;

  always @(posedge clock or negedge clearN)
    if (!clearN) setResponse3 <= '0;
    else         setResponse3 <= ~setRequest3;

  cache_set_arbiter #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (W),
    .SET_LATENCY (3)
  ) u_dut3 (
    .clock       (clock),
    .clearN      (clearN),
    .reqValid    (reqValid3),
    .reqData     (reqData3),
    .reqReady    (reqReady3),
    .respValid   (respValid3),
    .respData    (respData3),
    .respReady   (respReady3),
    .setRequest  (setRequest3),
    .setResponse (setResponse3),
    .busy        (busy3),
    .grantId     (grantId3)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
  } resp_t;

  int    grantQ[$];
  resp_t respQ[$];
  int    nChecks = 0;
  int    nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    reqData[i*W +: W] = v;
  endtask

  task automatic expect_txn(input int id, input logic [7:0] d);
    resp_t r;
    r.id   = id;
    r.data = ~d;
    grantQ.push_back(id);
    respQ.push_back(r);
  endtask

  task automatic wait_grants(input int maxc);
    int n;
    n = 0;
    while (grantQ.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    if (grantQ.size() != 0) check("grant_timeout", grantQ.size(), 0);
  endtask

  task automatic wait_resps(input int maxc);
    int n;
    n = 0;
    while (respQ.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    if (respQ.size() != 0) check("resp_timeout", respQ.size(), 0);
  endtask

  // Monitor: pop and compare on every grant and every response handshake.
  int    mg;
  resp_t mr;
  always @(negedge clock) begin
    if (clearN) begin
      if ((reqReady & reqValid) != '0) begin
        if (grantQ.size() == 0) check("unexpected_grant", reqReady, 0);
        else begin
          mg = grantQ.pop_front();
          check("grant_order", reqReady, 32'd1 << mg);
        end
      end
      if ((respValid & respReady) != '0) begin
        if (respQ.size() == 0) check("unexpected_resp", respValid, 0);
        else begin
          mr = respQ.pop_front();
          check("resp_owner", respValid, 32'd1 << mr.id);
          check("resp_data", respData, mr.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] heldData;

  initial begin
    reqValid = '0; reqData = '0; respReadyMan = '0; autoAck = 1'b0;
    reqValid3 = '0; reqData3 = '0; respReady3 = '0;

    // Reset values
    #2;
    check("rst_reqReady", reqReady, 0);
    check("rst_respValid", respValid, 0);
    check("rst_busy", busy, 0);
    check("rst_grantId", grantId, 0);
    check("rst_setRequest", setRequest, 0);
    check("rst_respData", respData, 0);
    tick(); tick();
    clearN = 1'b1;
    tick();

    // Single request from requester 2
    set_data(2, 8'h5A);
    reqValid = 4'b0100;
    expect_txn(2, 8'h5A);
    tick();
    reqValid = '0;
    check("t1_setRequest", setRequest, 8'h5A);
    check("t1_busy", busy, 1);
    check("t1_grantId", grantId, 2);
    check("t1_respValid_k1", respValid, 0);
    tick();
    check("t1_respValid_k2", respValid, 0);
    tick();
    check("t1_respValid", respValid, 4'b0100);
    check("t1_respData", respData, 8'hA5);
    tick(); tick();
    check("t1_hold_valid", respValid, 4'b0100);
    respReadyMan = 4'b0100;
    tick();
    respReadyMan = '0;
    check("t1_idle", busy, 0);
    wait_resps(5);

    // All four continuously valid from ptr=0
    clearN = 1'b0;
    #1;
    check("rst2_busy", busy, 0);
    tick();
    clearN = 1'b1;
    tick();
    autoAck = 1'b1;
    set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'h33); set_data(3, 8'h44);
    expect_txn(0, 8'h11); expect_txn(1, 8'h22); expect_txn(2, 8'h33);
    expect_txn(3, 8'h44); expect_txn(0, 8'h11);
    reqValid = 4'b1111;
    wait_grants(40);
    reqValid = '0;
    wait_resps(10);
    tick(); tick();

    // ptr=2 after grant to 1, then requesters 3 and 0
    reqValid = 4'b0010;
    expect_txn(1, 8'h22);
    wait_grants(10);
    reqValid = '0;
    wait_resps(10);
    tick();
    reqValid = 4'b1001;
    expect_txn(3, 8'h44); expect_txn(0, 8'h11);
    wait_grants(20);
    reqValid = '0;
    wait_resps(10);
    tick(); tick();

    // Response backpressure (ptr=1 -> requester 0)
    autoAck = 1'b0;
    reqValid = 4'b0001;
    expect_txn(0, 8'h11);
    wait_grants(10);
    reqValid = '0;
    for (int i = 0; i < 10 && respValid == '0; i++) tick();
    check("bp_respValid", respValid, 4'b0001);
    heldData = respData;
    reqValid = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_stable", respValid, 4'b0001);
      check("bp_data_stable", respData, heldData);
      check("bp_busy", busy, 1);
      check("bp_no_reqReady", reqReady, 0);
    end
    expect_txn(1, 8'h22);
    respReadyMan = 4'b0001;
    tick();
    respReadyMan = '0;
    check("bp_idle", busy, 0);
    check("bp_next_grant", reqReady, 4'b0010);
    autoAck = 1'b1;
    wait_grants(5);
    reqValid = '0;
    wait_resps(10);
    tick(); tick();

    // Reset during WAIT
    reqValid = 4'b0100;
    expect_txn(2, 8'h33);
    wait_grants(10);
    reqValid = '0;
    check("rw_in_wait", busy, 1);
    #2;
    clearN = 1'b0;
    #1;
    respQ.delete();
    check("rw_busy", busy, 0);
    check("rw_respValid", respValid, 0);
    check("rw_grantId", grantId, 0);
    check("rw_setRequest", setRequest, 0);
    check("rw_respData", respData, 0);
    reqValid = 4'b1010;
    #1;
    check("rw_reqReady_in_reset", reqReady, 0);
    tick(); tick();
    expect_txn(1, 8'h22);
    clearN = 1'b1;
    wait_grants(5);
    reqValid = '0;
    wait_resps(10);
    tick(); tick();
    autoAck = 1'b0;

    // SET_LATENCY=3 instance
    reqData3[1*W +: W] = 8'h3C;
    reqValid3 = 4'b0010;
    @(negedge clock);
    check("l3_reqReady", reqReady3, 4'b0010);
    @(posedge clock);
    #1;
    reqValid3 = '0;
    check("l3_setRequest", setRequest3, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("l3_no_resp_yet", respValid3, 0);
    end
    tick();
    check("l3_respValid", respValid3, 4'b0010);
    check("l3_respData", respData3, 8'hC3);
    respReady3 = 4'b0010;
    tick();
    respReady3 = '0;
    check("l3_idle", busy3, 0);

    check("grants_outstanding", grantQ.size(), 0);
    check("resps_outstanding", respQ.size(), 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/cache_set_arbiter.md
# cache_set_arbiter

Round-robin arbiter and sequencer that shares one CacheSet datapath (8-bit request in, registered 8-bit response out) among NUM_REQ requesters. It accepts one request at a time over a valid/ready handshake, drives it onto the set, waits the set's fixed latency, and captures the response. It returns the response to the winning requester, holding it until that requester acknowledges. It sits between client blocks and a CacheSet instance, in place of a direct CacheSetInterface binding.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- DATA_WIDTH, default 8: request/response width; must match the set.
- SET_LATENCY, default 1: set response latency in clock edges after the request is stable, 1..7.

- clock  in  1  sole clock, rising edge.
- clearN  in  1  reset; one clock; reset is asynchronous and active-low.
- reqValid  in  NUM_REQ  per-requester request valid.
- reqData  in  NUM_REQ×DATA_WIDTH  per-requester request payload.
- reqReady  out  NUM_REQ  one-hot grant/accept strobe.
- respValid  out  NUM_REQ  one-hot response valid to the owning requester.
- respData  out  DATA_WIDTH  shared response payload; qualified by respValid.
- respReady  in  NUM_REQ  per-requester response accept.
- setRequest  out  DATA_WIDTH  drives the set's request.
- setResponse  in  DATA_WIDTH  the set's response.
- busy  out  1  high in any state other than IDLE.
- grantId  out  $clog2(NUM_REQ)  index of the current or last owner.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - The picker scans reqValid starting at pointer `ptr`, wrapping modulo NUM_REQ. The first set bit is winner w.
  - reqReady[w]=1 combinationally. It is 0 for all others and 0 in every other state.
  - If any valid: on the edge, setRequest←reqData[w], grantId←w, ptr←(w+1) mod NUM_REQ, cnt←SET_LATENCY, go to WAIT.
  - If none valid: stay in IDLE; ptr unchanged.
- **WAIT**
  - If cnt≠0: cnt decrements each edge.
  - If cnt==0: on the edge, respData←setResponse, go to RESP.
- **RESP**
  - respValid[grantId]=1, decoded from state and grantId.
  - If respReady[grantId]=1: go to IDLE on that edge.
  - Otherwise hold, with respData stable.
  - respReady bits of non-owners are ignored.
- setRequest holds its last accepted value outside acceptance edges.
- reqData is sampled only on the acceptance edge. Later changes are ignored.
- A requester may keep reqValid high across transactions. Round-robin guarantees service of every asserted requester within NUM_REQ grants.
- Reset values:
  - state=IDLE, ptr=0, cnt=0, grantId=0.
  - setRequest=0, respData=0.
  - respValid=0, reqReady=0 while clearN low, busy=0.
- Reset mid-operation: the in-flight transaction is dropped with no response. The first request after reset is arbitrated from ptr=0.

## Timing
- Acceptance edge k (reqValid[w]&&reqReady[w]): setRequest is valid after k. respValid rises after edge k+SET_LATENCY+1.
- Default latency is 2 cycles from the acceptance edge to respValid.
- respReady high in the first RESP cycle: back in IDLE after the next edge. The next acceptance can occur one cycle later.
- Minimum spacing between acceptances: SET_LATENCY+3 cycles.
- reqReady depends combinationally on reqValid and state only, never on respReady.

## Structure
- Package cache_arb_pkg contains:
  - the FSM state enum typedef (IDLE, WAIT, RESP);
  - default parameter constants;
  - a function computing the grantId width.
- Sub-module rr_picker: a purely combinational round-robin picker. Inputs are reqValid and ptr; outputs are one-hot grant, winner index, and anyValid.
- The arbiter holds the FSM, cnt, ptr, and the data registers.

## Test plan
- Single request, default parameters:
  - stimulus: requester 2 sends 8'h5A.
  - required: reqReady[2] pulses once; respValid[2] appears 2 cycles later with respData=8'hA5 (inverting set); it holds until respReady[2].
- All four valid continuously, with immediate respReady:
  - required: grant order 0,1,2,3,0; each response equals ~reqData of its owner.
- ptr=2 after a grant to requester 1, then reqValid=4'b1001:
  - required: requester 3 is granted before requester 0.
- Response backpressure:
  - stimulus: respReady held low for 5 cycles.
  - required: respValid and respData stable; busy=1; no reqReady pulses.
  - after release: IDLE next cycle.
- clearN asserted during WAIT:
  - required: outputs reset asynchronously; no respValid appears.
  - after release: the next grant goes to the lowest-index valid requester.
- SET_LATENCY=3:
  - required: respValid rises 4 cycles after the acceptance edge, with the correct data.
